// File: rtl/awg_pkg.sv
// Shared types and helpers for the AWG sample-buffer unpacking path.
package awg_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} unpack_state_t;

    function automatic int beats_per_word(input int data_w, input int lanes, input int sample_w);
        return data_w / (lanes * sample_w);
    endfunction

endpackage

// File: rtl/awg_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module awg_sat_counter #(
    parameter int P_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [P_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? P_WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + P_WIDTH'(1);
        end
    end

endmodule

// File: rtl/awg_fifo_unpacker.sv
// Pops wide words from an FWFT FIFO and streams them out as P_LANES-sample beats,
// LSB beat first, tracking starvation while running.
module awg_fifo_unpacker
    import awg_pkg::*;
#(
    parameter int P_DATA_WIDTH   = 512,
    parameter int P_SAMPLE_WIDTH = 16,
    parameter int P_LANES        = 4,
    parameter int P_CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              flush,
    input  logic                              clr_status,
    input  logic [P_DATA_WIDTH-1:0]           fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [P_LANES*P_SAMPLE_WIDTH-1:0] m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              busy,
    output logic                              underflow,
    output logic [P_CNT_WIDTH-1:0]            underflow_cnt,
    output logic [P_CNT_WIDTH-1:0]            word_cnt
);

    localparam int BEAT_W  = P_LANES * P_SAMPLE_WIDTH;
    localparam int P_BEATS = beats_per_word(P_DATA_WIDTH, P_LANES, P_SAMPLE_WIDTH);
    localparam int IDX_W   = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;

    generate
        if ((P_DATA_WIDTH % BEAT_W) != 0 || P_BEATS < 2) begin : g_bad_geometry
            $error("awg_fifo_unpacker: P_DATA_WIDTH must be a multiple (>=2) of P_LANES*P_SAMPLE_WIDTH");
        end
    endgenerate

    unpack_state_t                        state;
    unpack_state_t                        state_nxt;
    logic [P_BEATS-1:0][BEAT_W-1:0]       data_buf;
    logic                                 buf_vld;
    logic [IDX_W-1:0]                     beat_idx;
    logic                                 last;
    logic                                 xfer;
    logic                                 rd_allow;
    logic                                 underflow_evt;

    assign last          = (beat_idx == IDX_W'(P_BEATS - 1));
    assign xfer          = buf_vld && m_ready;
    assign rd_allow      = (state == PRIME) || (state == RUN);
    assign fifo_rd_en    = rd_allow && !fifo_empty && !flush && (!buf_vld || (m_ready && last));
    assign underflow_evt = (state == RUN) && m_ready && !buf_vld;
    assign m_data        = data_buf[beat_idx];
    assign m_valid       = buf_vld;
    assign busy          = (state != IDLE);

    // A pop coinciding with the last-beat accept reloads the buffer, keeping output gapless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_buf <= '0;
            buf_vld  <= 1'b0;
            beat_idx <= '0;
            word_cnt <= '0;
        end else if (flush) begin
            buf_vld  <= 1'b0;
            beat_idx <= '0;
        end else if (fifo_rd_en) begin
            data_buf <= fifo_dout;
            buf_vld  <= 1'b1;
            beat_idx <= '0;
            word_cnt <= word_cnt + P_CNT_WIDTH'(1);
        end else if (xfer) begin
            if (last) begin
                buf_vld <= 1'b0;
            end else begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = enable ? PRIME : IDLE;
        end else begin
            case (state)
                IDLE:  if (enable) state_nxt = PRIME;
                PRIME: begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (fifo_rd_en) begin
                        state_nxt = RUN;
                    end
                end
                RUN:   if (!enable) state_nxt = buf_vld ? DRAIN : IDLE;
                DRAIN: if (!buf_vld || (xfer && last)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Starvation wins over a coincident clear so no event is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (underflow_evt) begin
            underflow <= 1'b1;
        end else if (clr_status) begin
            underflow <= 1'b0;
        end
    end

    awg_sat_counter #(
        .P_WIDTH (P_CNT_WIDTH)
    ) u_underflow_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_status),
        .inc   (underflow_evt),
        .count (underflow_cnt)
    );

endmodule

// File: tb/tb_awg_fifo_unpacker.sv
// Directed bench for awg_fifo_unpacker driven from a small FWFT FIFO model.
module tb_awg_fifo_unpacker;

    localparam int DW = 512;
    localparam int SW = 16;
    localparam int LN = 4;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic            enable;
    logic            flush;
    logic            clr_status;
    logic [DW-1:0]   fifo_dout;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic [63:0]     m_data;
    logic            m_valid;
    logic            m_ready;
    logic            busy;
    logic            underflow;
    logic [CW-1:0]   underflow_cnt;
    logic [CW-1:0]   word_cnt;

    logic [DW-1:0]   mem [0:15];
    int unsigned     rd_ptr;
    int unsigned     wr_ptr;
    int              tests_run;
    int              tests_failed;

    typedef struct {
        bit ready;
        bit exp_valid;
        int base;
        int beat;
        bit exp_rd;
    } vec_t;

    vec_t vecs [32];

    awg_fifo_unpacker #(
        .P_DATA_WIDTH   (DW),
        .P_SAMPLE_WIDTH (SW),
        .P_LANES        (LN),
        .P_CNT_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .clr_status    (clr_status),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .word_cnt      (word_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_dout  = mem[rd_ptr % 16];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    function automatic logic [DW-1:0] make_word(input int base);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) w[k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    function automatic logic [63:0] exp_beat(input int base, input int b);
        return {16'(base + 4*b + 3), 16'(base + 4*b + 2), 16'(base + 4*b + 1), 16'(base + 4*b)};
    endfunction

    task automatic pushWord(input int base);
        mem[wr_ptr % 16] = make_word(base);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic fl, input logic clr);
        @(negedge clk);
        enable     = en;
        m_ready    = rdy;
        flush      = fl;
        clr_status = clr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int unsigned lvl;
        tests_run    = 0;
        tests_failed = 0;
        rd_ptr       = 0;
        wr_ptr       = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst        = 1'b1;
        enable     = 1'b1;
        flush      = 1'b0;
        clr_status = 1'b0;
        m_ready    = 1'b1;
        pushWord(0);
        pushWord(32);

        // Reset state with a non-empty FIFO and enable high
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_data", m_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_uflag", underflow, 0);
        checkOutput("rst_ucnt", underflow_cnt, 0);
        checkOutput("rst_wcnt", word_cnt, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);

        // Two preloaded words stream out as 16 back-to-back beats
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_valid", m_valid, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("prime_pop", fifo_rd_en, 1);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(1, 1, 0, 0);
                checkOutput($sformatf("stream_w%0d_b%0d_valid", w, b), m_valid, 1);
                checkOutput($sformatf("stream_w%0d_b%0d_data", w, b), m_data, exp_beat(w*32, b));
            end
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("stream_end_valid", m_valid, 0);
        checkOutput("stream_pop_pulses", rd_ptr, 2);
        checkOutput("stream_wcnt", word_cnt, 2);
        pushWord(64);
        pushWord(96);
        #1;
        checkOutput("refill_pop", fifo_rd_en, 1);

        // Stall/accept alternation across two words
        for (int i = 0; i < 32; i++) begin
            vecs[i].ready     = (i % 2) == 1;
            vecs[i].exp_valid = 1'b1;
            vecs[i].base      = 64 + 32 * (i / 16);
            vecs[i].beat      = (i % 16) / 2;
            vecs[i].exp_rd    = vecs[i].ready && (vecs[i].beat == 7) && (i < 16);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, vecs[i].ready, 0, 0);
            checkOutput($sformatf("stall_r%0d_valid", i), m_valid, vecs[i].exp_valid);
            checkOutput($sformatf("stall_r%0d_data", i), m_data, exp_beat(vecs[i].base, vecs[i].beat));
            checkOutput($sformatf("stall_r%0d_rd", i), fifo_rd_en, vecs[i].exp_rd);
        end

        // Five starved cycles, the last one coinciding with the refill pop
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (i == 0) checkOutput("starve_uflag_before", underflow, 0);
            if (i == 4) begin
                pushWord(128);
                #1;
            end
            checkOutput($sformatf("starve_%0d_valid", i), m_valid, 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("starve_uflag", underflow, 1);
        checkOutput("starve_ucnt", underflow_cnt, 5);
        checkOutput("resume_data", m_data, exp_beat(128, 0));

        // Clear coincident with a starvation event, then a plain clear
        for (int b = 0; b < 8; b++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput($sformatf("w4_b%0d_data", b), m_data, exp_beat(128, b));
        end
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("clr_evt_uflag", underflow, 1);
        checkOutput("clr_evt_ucnt", underflow_cnt, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("clr_uflag", underflow, 0);
        checkOutput("clr_ucnt", underflow_cnt, 0);

        // Saturation of the 4-bit starvation counter
        repeat (14) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("sat_ucnt_14", underflow_cnt, 14);
        repeat (3) applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("sat_ucnt_15", underflow_cnt, 15);
        checkOutput("sat_uflag", underflow, 1);

        // Enable dropped at beat 3: remaining beats drain without a pop
        applyStimulus(1, 0, 0, 0);
        pushWord(160);
        pushWord(192);
        #1;
        checkOutput("drain_load_pop", fifo_rd_en, 1);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput($sformatf("drain_pre_b%0d", b), m_data, exp_beat(160, b));
        end
        applyStimulus(0, 1, 0, 0);
        checkOutput("drain_b3_data", m_data, exp_beat(160, 3));
        checkOutput("drain_b3_rd", fifo_rd_en, 0);
        for (int b = 4; b < 8; b++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("drain_b%0d_data", b), m_data, exp_beat(160, b));
            checkOutput($sformatf("drain_b%0d_rd", b), fifo_rd_en, 0);
            checkOutput($sformatf("drain_b%0d_busy", b), busy, 1);
        end
        applyStimulus(0, 1, 0, 0);
        checkOutput("drain_done_busy", busy, 0);
        checkOutput("drain_done_valid", m_valid, 0);
        checkOutput("drain_fifo_level", wr_ptr - rd_ptr, 1);
        checkOutput("drain_wcnt", word_cnt, 6);

        // Flush at beat 5, next word restarts at beat 0
        applyStimulus(1, 1, 0, 0);
        pushWord(224);
        applyStimulus(1, 1, 0, 0);
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput($sformatf("flush_pre_b%0d", b), m_data, exp_beat(192, b));
        end
        applyStimulus(1, 1, 1, 0);
        checkOutput("flush_b5_data", m_data, exp_beat(192, 5));
        checkOutput("flush_rd", fifo_rd_en, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("flush_after_valid", m_valid, 0);
        checkOutput("flush_after_pop", fifo_rd_en, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("flush_next_b0", m_data, exp_beat(224, 0));
        applyStimulus(1, 1, 0, 0);
        checkOutput("flush_next_b1", m_data, exp_beat(224, 1));

        // Asynchronous reset mid-run with a word waiting in the FIFO
        applyStimulus(1, 1, 0, 0);
        pushWord(256);
        #1;
        lvl = wr_ptr - rd_ptr;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", m_valid, 0);
        checkOutput("arst_data", m_data, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_uflag", underflow, 0);
        checkOutput("arst_ucnt", underflow_cnt, 0);
        checkOutput("arst_wcnt", word_cnt, 0);
        checkOutput("arst_rd_en", fifo_rd_en, 0);
        @(posedge clk);
        #1;
        checkOutput("arst_fifo_level", wr_ptr - rd_ptr, lvl);
        checkOutput("arst_fifo_level_one", wr_ptr - rd_ptr, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
